// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: bundles the ID-stage decode inputs and the registered
// pipeline control outputs of pipe_hazard_ctrl.
//   slave  : the control unit (consumes ID fields, drives controls)
//   master : whoever presents the ID-stage instruction (IF/ID, bench)
// ID side : id_valid, opcode, funct, id_rs/id_rt/id_rd, equal
// Front   : pc_write, ifid_write, if_flush, pc_src
// ID/EX   : ex_alu_src, ex_reg_write, ex_mem_write, ex_mem_read,
//           ex_mem_to_reg, ex_link, ex_reg_dst, ex_alu_op, ex_dest
// EX/MEM  : mem_reg_write, mem_mem_to_reg, mem_dest
// Status  : mul_busy
interface pipe_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 3
);
  logic                  id_valid;
  logic [5:0]            opcode;
  logic [5:0]            funct;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  equal;

  logic                  pc_write;
  logic                  ifid_write;
  logic                  if_flush;
  logic [1:0]            pc_src;

  logic                  ex_alu_src;
  logic                  ex_reg_write;
  logic                  ex_mem_write;
  logic                  ex_mem_read;
  logic                  ex_mem_to_reg;
  logic                  ex_link;
  logic [1:0]            ex_reg_dst;
  logic [ALUOP_W-1:0]    ex_alu_op;
  logic [REG_ADDR_W-1:0] ex_dest;

  logic                  mem_reg_write;
  logic                  mem_mem_to_reg;
  logic [REG_ADDR_W-1:0] mem_dest;
  logic                  mul_busy;

  modport master (
    output id_valid, opcode, funct, id_rs, id_rt, id_rd, equal,
    input  pc_write, ifid_write, if_flush, pc_src,
    input  ex_alu_src, ex_reg_write, ex_mem_write, ex_mem_read,
    input  ex_mem_to_reg, ex_link, ex_reg_dst, ex_alu_op, ex_dest,
    input  mem_reg_write, mem_mem_to_reg, mem_dest, mul_busy
  );

  modport slave (
    input  id_valid, opcode, funct, id_rs, id_rt, id_rd, equal,
    output pc_write, ifid_write, if_flush, pc_src,
    output ex_alu_src, ex_reg_write, ex_mem_write, ex_mem_read,
    output ex_mem_to_reg, ex_link, ex_reg_dst, ex_alu_op, ex_dest,
    output mem_reg_write, mem_mem_to_reg, mem_dest, mul_busy
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard-aware control unit for the 5-stage MIPS pipeline.
// Decodes the ID instruction, resolves beq/bne/j/jal in ID, owns the ID/EX
// and EX/MEM control registers, stalls on load-use and branch-operand
// hazards, and freezes the front end while a multi-cycle mult sits in EX.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : pipe_hazard_ctrl_if.slave (ID fields in, pipeline controls out)
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 3,
  parameter int MUL_LAT    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int CNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_MULT  = 6'b011000;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] ALU_RF  = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3'b011);
  localparam logic [ALUOP_W-1:0] ALU_MUL = ALUOP_W'(3'b100);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  typedef struct packed {
    logic               alu_src;
    logic               reg_write;
    logic               mem_write;
    logic               mem_read;
    logic               mem_to_reg;
    logic               link;
    logic [1:0]         reg_dst;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '0;

  ctrl_t                 ex_q, ex_d, dec;
  logic [REG_ADDR_W-1:0] ex_dest_q, ex_dest_d, id_dest;
  logic                  mem_reg_write_q, mem_reg_write_d;
  logic                  mem_mem_to_reg_q, mem_mem_to_reg_d;
  logic [REG_ADDR_W-1:0] mem_dest_q, mem_dest_d;
  logic [0:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic is_beq, is_bne, is_jmp, is_mult, uses_rt;
  logic busy, mul_last, load_use, br_stall, stall, taken;
  logic ex_hit, mem_hit;

  // ---------------- decode ----------------
  always_comb begin
    dec     = BUBBLE;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_jmp  = 1'b0;
    is_mult = 1'b0;
    uses_rt = 1'b0;
    if (bus.id_valid) begin
      case (bus.opcode)
        OP_RTYPE: begin
          dec.reg_write = 1'b1;
          dec.reg_dst   = 2'b01;
          uses_rt       = 1'b1;
          if (bus.funct == FN_MULT) begin
            dec.alu_op = ALU_MUL;
            is_mult    = 1'b1;
          end else begin
            dec.alu_op = ALU_RF;
          end
        end
        OP_ADDI: begin
          dec.alu_src   = 1'b1;
          dec.reg_write = 1'b1;
          dec.alu_op    = ALU_ADD;
        end
        OP_ANDI: begin
          dec.alu_src   = 1'b1;
          dec.reg_write = 1'b1;
          dec.alu_op    = ALU_AND;
        end
        OP_LW: begin
          dec.alu_src    = 1'b1;
          dec.reg_write  = 1'b1;
          dec.mem_read   = 1'b1;
          dec.mem_to_reg = 1'b1;
        end
        OP_SW: begin
          dec.alu_src   = 1'b1;
          dec.mem_write = 1'b1;
          uses_rt       = 1'b1;
        end
        OP_BEQ: begin
          dec.alu_op = ALU_SUB;
          is_beq     = 1'b1;
          uses_rt    = 1'b1;
        end
        OP_BNE: begin
          dec.alu_op = ALU_SUB;
          is_bne     = 1'b1;
          uses_rt    = 1'b1;
        end
        OP_J:    is_jmp = 1'b1;
        OP_JAL: begin
          dec.reg_write = 1'b1;
          dec.reg_dst   = 2'b10;
          dec.link      = 1'b1;
          is_jmp        = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Destination is forced to 0 for non-writers so that r0 comparisons
  // naturally suppress hazards.
  always_comb begin
    id_dest = '0;
    if (dec.reg_write) begin
      case (dec.reg_dst)
        2'b00:   id_dest = bus.id_rt;
        2'b01:   id_dest = bus.id_rd;
        default: id_dest = REG_ADDR_W'(31);
      endcase
    end
  end

  // ---------------- hazards / front end ----------------
  assign busy     = (state_q == S_BUSY);
  assign mul_last = busy && (cnt_q == CNT_W'(1));

  assign ex_hit  = (ex_dest_q != '0) &&
                   ((ex_dest_q == bus.id_rs) || (ex_dest_q == bus.id_rt));
  assign mem_hit = (mem_dest_q != '0) &&
                   ((mem_dest_q == bus.id_rs) || (mem_dest_q == bus.id_rt));

  assign load_use = bus.id_valid && ex_q.mem_read && (ex_dest_q != '0) &&
                    ((ex_dest_q == bus.id_rs) ||
                     (uses_rt && (ex_dest_q == bus.id_rt)));

  // Branches compare in ID, so any in-flight producer not yet forwardable
  // to ID (ALU result in EX, load data in MEM) must drain first.
  assign br_stall = (is_beq || is_bne) &&
                    ((ex_q.reg_write && ex_hit) || (mem_mem_to_reg_q && mem_hit));

  assign stall = busy || load_use || br_stall;
  assign taken = (is_beq && bus.equal) || (is_bne && !bus.equal);

  always_comb begin
    bus.pc_src   = 2'b00;
    bus.if_flush = 1'b0;
    if (!stall && taken) begin
      bus.pc_src   = 2'b01;
      bus.if_flush = 1'b1;
    end else if (!stall && is_jmp) begin
      bus.pc_src   = 2'b10;
      bus.if_flush = 1'b1;
    end
  end

  assign bus.pc_write   = !stall;
  assign bus.ifid_write = !stall;

  // ---------------- next state ----------------
  always_comb begin
    ex_d             = ex_q;
    ex_dest_d        = ex_dest_q;
    mem_reg_write_d  = ex_q.reg_write;
    mem_mem_to_reg_d = ex_q.mem_to_reg;
    mem_dest_d       = ex_dest_q;
    state_d          = state_q;
    cnt_d            = cnt_q;
    if (busy) begin
      if (mul_last) begin
        // mult leaves EX into EX/MEM; front end was frozen, so EX gets a bubble
        state_d   = S_IDLE;
        cnt_d     = '0;
        ex_d      = BUBBLE;
        ex_dest_d = '0;
      end else begin
        cnt_d            = cnt_q - CNT_W'(1);
        mem_reg_write_d  = 1'b0;
        mem_mem_to_reg_d = 1'b0;
        mem_dest_d       = '0;
      end
    end else begin
      if (stall) begin
        ex_d      = BUBBLE;
        ex_dest_d = '0;
      end else begin
        ex_d      = dec;
        ex_dest_d = id_dest;
        if (is_mult) begin
          state_d = S_BUSY;
          cnt_d   = CNT_W'(MUL_LAT - 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q             <= BUBBLE;
      ex_dest_q        <= '0;
      mem_reg_write_q  <= 1'b0;
      mem_mem_to_reg_q <= 1'b0;
      mem_dest_q       <= '0;
      state_q          <= S_IDLE;
      cnt_q            <= '0;
    end else begin
      ex_q             <= ex_d;
      ex_dest_q        <= ex_dest_d;
      mem_reg_write_q  <= mem_reg_write_d;
      mem_mem_to_reg_q <= mem_mem_to_reg_d;
      mem_dest_q       <= mem_dest_d;
      state_q          <= state_d;
      cnt_q            <= cnt_d;
    end
  end

  assign bus.ex_alu_src     = ex_q.alu_src;
  assign bus.ex_reg_write   = ex_q.reg_write;
  assign bus.ex_mem_write   = ex_q.mem_write;
  assign bus.ex_mem_read    = ex_q.mem_read;
  assign bus.ex_mem_to_reg  = ex_q.mem_to_reg;
  assign bus.ex_link        = ex_q.link;
  assign bus.ex_reg_dst     = ex_q.reg_dst;
  assign bus.ex_alu_op      = ex_q.alu_op;
  assign bus.ex_dest        = ex_dest_q;
  assign bus.mem_reg_write  = mem_reg_write_q;
  assign bus.mem_mem_to_reg = mem_mem_to_reg_q;
  assign bus.mem_dest       = mem_dest_q;
  assign bus.mul_busy       = busy;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: drives instruction streams into pipe_hazard_ctrl and
// checks every cycle against an instruction-level pipeline model through a
// scoreboard queue, plus directed stall-count and reset checks.
module tb_pipe_hazard_ctrl;
  localparam int MUL_LAT = 4;

  localparam int K_NONE = 0, K_R = 1, K_MULT = 2, K_ADDI = 3, K_ANDI = 4,
                 K_LW = 5, K_SW = 6, K_BEQ = 7, K_BNE = 8, K_J = 9, K_JAL = 10;

  typedef struct packed {
    logic       v;
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    logic       eq;
  } ins_t;

  typedef struct packed {
    logic       pcw, ifw, ifl;
    logic [1:0] psrc;
    logic       asrc, rw, mw, mr, m2r, lnk;
    logic [1:0] rdst;
    logic [2:0] aop;
    logic [4:0] ed;
    logic       mrw, mm2r;
    logic [4:0] md;
    logic       busy;
  } obs_t;

  localparam ins_t BUB = '0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_ADDR_W(5), .ALUOP_W(3)) bus();

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .ALUOP_W(3), .MUL_LAT(MUL_LAT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int   n_chk = 0;
  int   n_fail = 0;
  int   dut_stalls = 0;
  obs_t sbq[$];
  ins_t prog_q[$];

  // model: which instruction sits in EX / MEM, and how many frozen cycles remain
  ins_t m_ex = BUB, m_mem = BUB;
  int   m_mul_left = 0;

  function automatic int kind_of(input ins_t i);
    if (!i.v) return K_NONE;
    case (i.op)
      6'h00: return (i.fn == 6'h18) ? K_MULT : K_R;
      6'h08: return K_ADDI;
      6'h0c: return K_ANDI;
      6'h23: return K_LW;
      6'h2b: return K_SW;
      6'h04: return K_BEQ;
      6'h05: return K_BNE;
      6'h02: return K_J;
      6'h03: return K_JAL;
      default: return K_NONE;
    endcase
  endfunction

  function automatic logic writes(input int k);
    return k inside {K_R, K_MULT, K_ADDI, K_ANDI, K_LW, K_JAL};
  endfunction

  function automatic logic [4:0] dest_of(input ins_t i);
    case (kind_of(i))
      K_R, K_MULT:         return i.rd;
      K_ADDI, K_ANDI, K_LW: return i.rt;
      K_JAL:               return 5'd31;
      default:             return 5'd0;
    endcase
  endfunction

  function automatic ins_t mk(input logic [5:0] op, input logic [5:0] fn,
                              input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic eq);
    ins_t i;
    i.v = 1'b1; i.op = op; i.fn = fn; i.rs = rs; i.rt = rt; i.rd = rd; i.eq = eq;
    return i;
  endfunction

  task automatic model_reset();
    m_ex = BUB; m_mem = BUB; m_mul_left = 0;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: present id, push the model's expected outputs, advance the model.
  task automatic step(input ins_t id, output logic acc, output logic fl);
    obs_t e;
    int k, ke, km;
    logic [4:0] ed, md;
    logic ut, lu, br, stl, tk;
    @(posedge clk); #1;
    bus.id_valid = id.v; bus.opcode = id.op; bus.funct = id.fn;
    bus.id_rs = id.rs; bus.id_rt = id.rt; bus.id_rd = id.rd; bus.equal = id.eq;
    k  = kind_of(id); ke = kind_of(m_ex); km = kind_of(m_mem);
    ed = dest_of(m_ex); md = dest_of(m_mem);
    ut = k inside {K_R, K_MULT, K_BEQ, K_BNE, K_SW};
    lu = id.v && (ke == K_LW) && (ed != 0) && (ed == id.rs || (ut && ed == id.rt));
    br = (k == K_BEQ || k == K_BNE) &&
         ((ed != 0 && (ed == id.rs || ed == id.rt)) ||
          (km == K_LW && md != 0 && (md == id.rs || md == id.rt)));
    stl = (m_mul_left > 0) || lu || br;
    tk  = (k == K_BEQ && id.eq) || (k == K_BNE && !id.eq);
    e = '0;
    e.pcw = !stl; e.ifw = !stl;
    if (!stl && tk) begin e.psrc = 2'b01; e.ifl = 1'b1; end
    else if (!stl && (k == K_J || k == K_JAL)) begin e.psrc = 2'b10; e.ifl = 1'b1; end
    case (ke)
      K_R:    begin e.rw = 1; e.rdst = 2'd1; e.aop = 3'd2; end
      K_MULT: begin e.rw = 1; e.rdst = 2'd1; e.aop = 3'd4; end
      K_ADDI: begin e.asrc = 1; e.rw = 1; end
      K_ANDI: begin e.asrc = 1; e.rw = 1; e.aop = 3'd3; end
      K_LW:   begin e.asrc = 1; e.rw = 1; e.mr = 1; e.m2r = 1; end
      K_SW:   begin e.asrc = 1; e.mw = 1; end
      K_BEQ, K_BNE: e.aop = 3'd1;
      K_JAL:  begin e.rw = 1; e.rdst = 2'd2; e.lnk = 1; end
      default: ;
    endcase
    e.ed = ed; e.mrw = writes(km); e.mm2r = (km == K_LW); e.md = md;
    e.busy = (m_mul_left > 0);
    sbq.push_back(e);
    if (m_mul_left > 0) begin
      m_mul_left--;
      if (m_mul_left == 0) begin m_mem = m_ex; m_ex = BUB; end
      else m_mem = BUB;
    end else begin
      m_mem = m_ex;
      m_ex  = stl ? BUB : id;
      if (!stl && k == K_MULT) m_mul_left = MUL_LAT - 1;
    end
    acc = !stl; fl = e.ifl;
  endtask

  // Issue prog_q in order; a stalled instruction is re-presented, and a
  // flushed fetch slot shows up in ID as a bubble.
  task automatic run_prog();
    ins_t cur;
    logic acc, fl;
    int guard;
    guard = 0;
    while (prog_q.size() > 0 && guard < 5000) begin
      cur = prog_q[0];
      step(cur, acc, fl);
      guard++;
      if (acc) begin
        void'(prog_q.pop_front());
        if (fl) step(BUB, acc, fl);
      end
    end
    if (prog_q.size() > 0) begin
      n_chk++; n_fail++;
      $display("FAIL prog_timeout left=%0d exp=0", prog_q.size());
      prog_q.delete();
    end
  endtask

  task automatic drain(input int n);
    logic acc, fl;
    repeat (n) step(BUB, acc, fl);
  endtask

  task automatic seq_check(input string nm, input int exp_stalls);
    dut_stalls = 0;
    run_prog();
    drain(6);
    @(negedge clk); #1;
    chk(nm, dut_stalls, exp_stalls);
  endtask

  always @(negedge clk) begin
    obs_t e, a;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      a = {bus.pc_write, bus.ifid_write, bus.if_flush, bus.pc_src,
           bus.ex_alu_src, bus.ex_reg_write, bus.ex_mem_write, bus.ex_mem_read,
           bus.ex_mem_to_reg, bus.ex_link, bus.ex_reg_dst, bus.ex_alu_op,
           bus.ex_dest, bus.mem_reg_write, bus.mem_mem_to_reg, bus.mem_dest,
           bus.mul_busy};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle_check t=%0t got=%h exp=%h", $time, a, e);
      end
      if (!bus.pc_write) dut_stalls++;
    end
  end

  initial begin
    logic acc, fl;
    bus.id_valid = 0; bus.opcode = 0; bus.funct = 0;
    bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0; bus.equal = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_reg_write", bus.ex_reg_write, 0);
    chk("rst_mem_dest", bus.mem_dest, 0);
    chk("rst_mul_busy", bus.mul_busy, 0);
    chk("rst_pc_write", bus.pc_write, 1);
    #1 rst_n = 1'b1;

    // reset in the middle of a multiply (cnt==2)
    prog_q.push_back(mk(6'h00, 6'h18, 5'd1, 5'd2, 5'd3, 1'b0));
    run_prog();
    step(BUB, acc, fl);
    @(posedge clk); #2;
    chk("mul_busy_pre_rst", bus.mul_busy, 1);
    rst_n = 1'b0; #1;
    chk("mid_rst_mul_busy", bus.mul_busy, 0);
    chk("mid_rst_ex_reg_write", bus.ex_reg_write, 0);
    chk("mid_rst_ex_alu_op", bus.ex_alu_op, 0);
    chk("mid_rst_ex_dest", bus.ex_dest, 0);
    model_reset();
    @(negedge clk); rst_n = 1'b1; #1;
    chk("post_rst_pc_write", bus.pc_write, 1);
    chk("post_rst_ifid_write", bus.ifid_write, 1);
    chk("post_rst_if_flush", bus.if_flush, 0);
    chk("post_rst_pc_src", bus.pc_src, 0);

    // load-use: lw r8 ; add r9,r8,r1
    prog_q.push_back(mk(6'h23, 6'h00, 5'd1, 5'd8, 5'd0, 1'b0));
    prog_q.push_back(mk(6'h00, 6'h20, 5'd8, 5'd1, 5'd9, 1'b0));
    seq_check("stalls_load_use", 1);
    // addi r4 ; beq r4,r5 (taken)
    prog_q.push_back(mk(6'h08, 6'h00, 5'd0, 5'd4, 5'd0, 1'b0));
    prog_q.push_back(mk(6'h04, 6'h00, 5'd4, 5'd5, 5'd0, 1'b1));
    seq_check("stalls_alu_branch", 1);
    // lw r4 ; beq r4,r5 (taken)
    prog_q.push_back(mk(6'h23, 6'h00, 5'd0, 5'd4, 5'd0, 1'b0));
    prog_q.push_back(mk(6'h04, 6'h00, 5'd4, 5'd5, 5'd0, 1'b1));
    seq_check("stalls_lw_branch", 2);
    // jal ; bne with equal=1 (not taken)
    prog_q.push_back(mk(6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0));
    prog_q.push_back(mk(6'h05, 6'h00, 5'd1, 5'd2, 5'd0, 1'b1));
    seq_check("stalls_jal_bne", 0);
    // single mult, then back-to-back mults
    prog_q.push_back(mk(6'h00, 6'h18, 5'd1, 5'd2, 5'd6, 1'b0));
    seq_check("stalls_mult", MUL_LAT - 1);
    prog_q.push_back(mk(6'h00, 6'h18, 5'd1, 5'd2, 5'd6, 1'b0));
    prog_q.push_back(mk(6'h00, 6'h18, 5'd3, 5'd4, 5'd7, 1'b0));
    seq_check("stalls_mult_b2b", 2 * (MUL_LAT - 1));
    // r0 never hazards; unknown opcode is a bubble
    prog_q.push_back(mk(6'h23, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0));
    prog_q.push_back(mk(6'h00, 6'h20, 5'd0, 5'd0, 5'd1, 1'b0));
    prog_q.push_back(mk(6'h3f, 6'h3f, 5'd1, 5'd2, 5'd3, 1'b1));
    seq_check("stalls_reg0_unknown", 0);

    // randomized stream over a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      ins_t r;
      int s;
      s = $urandom_range(0, 11);
      r = mk(6'h00, 6'($urandom_range(0, 63)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)));
      case (s)
        0, 1: r.op = 6'h00;
        2:    r.op = 6'h08;
        3:    r.op = 6'h0c;
        4:    r.op = 6'h23;
        5:    r.op = 6'h2b;
        6:    r.op = 6'h04;
        7:    r.op = 6'h05;
        8:    r.op = 6'h02;
        9:    r.op = 6'h03;
        10:   begin r.op = 6'h00; r.fn = 6'h18; end
        default: r.op = 6'h3f;
      endcase
      r.v = ($urandom_range(0, 9) != 0);
      prog_q.push_back(r);
    end
    run_prog();
    drain(6);
    @(negedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Registered, hazard-aware control unit for the 5-stage MIPS pipeline. It decodes the ID-stage instruction and resolves beq/bne/j/jal in ID. It owns the ID/EX and EX/MEM control registers, detects load-use and branch-operand hazards, and stalls the front end for a parametrised multi-cycle multiply. It replaces the purely combinational decoder, which had no stall, flush or multi-cycle support.

## Interface
- REG_ADDR_W, 5, register-specifier width
- ALUOP_W, 3, width of ALU operation code
- MUL_LAT, 4, cycles a mult occupies EX (2..16)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  IF/ID holds a real instruction
- opcode  in  6  ID instruction [31:26]
- funct  in  6  ID instruction [5:0]
- id_rs, id_rt, id_rd  in  REG_ADDR_W each  ID register specifiers
- equal  in  1  ID-stage rs==rt comparator
- pc_write, ifid_write  out  1  enable PC / IF/ID update
- if_flush  out  1  zero IF/ID on next edge
- pc_src  out  2  00 PC+4, 01 branch target, 10 jump target
- ex_alu_src, ex_reg_write, ex_mem_write, ex_mem_read, ex_mem_to_reg, ex_link  out  1 each  ID/EX control
- ex_reg_dst  out  2  00 rt, 01 rd, 10 r31
- ex_alu_op  out  ALUOP_W  000 add, 001 sub, 010 R-funct, 011 and, 100 mul
- ex_dest  out  REG_ADDR_W  resolved EX destination (0 if no write)
- mem_reg_write, mem_mem_to_reg  out  1  EX/MEM control
- mem_dest  out  REG_ADDR_W  MEM destination
- mul_busy  out  1  multiply occupying EX

## Operation
- Decode (id_valid=1): R-type 000000 → reg_write, reg_dst=01, alu_op=010, except funct 011000 (mult) → alu_op=100, reg_dst=01. addi 001000 → alu_src, reg_write, alu_op=000. andi 001100 → alu_src, reg_write, alu_op=011. lw 100011 → alu_src, reg_write, mem_read, mem_to_reg. sw 101011 → alu_src, mem_write. beq 000100 / bne 000101 → alu_op=001, no write. j 000010 → none. jal 000011 → reg_write, reg_dst=10, link. Unknown opcode or id_valid=0 → all zero (bubble).
- Dest: reg_write ? (rt | rd | 31 by reg_dst) : 0. A write to register 0 never causes a hazard.
- uses_rt: R-type, beq, bne, sw.
- Load-use stall: ex_mem_read && ex_dest!=0 && (ex_dest==id_rs || (uses_rt && ex_dest==id_rt)).
- Branch stall (beq/bne only): (ex_reg_write && ex_dest matches rs/rt) || (mem_mem_to_reg && mem_dest matches rs/rt), nonzero dest.
- Priority: mul_busy > load-use stall > branch stall > redirect.
- On stall: pc_write=ifid_write=0, if_flush=0, pc_src=00; ID/EX loads bubble; the stalled branch does not redirect.
- Redirect (no stall): beq&&equal or bne&&!equal → pc_src=01, if_flush=1. j/jal → pc_src=10, if_flush=1. Otherwise pc_src=00.
- Multiply FSM, IDLE/BUSY: a mult entering ID/EX loads cnt=MUL_LAT-1 and goes to BUSY.
  - In BUSY: mul_busy=1, front end frozen, ID/EX holds (mult stays in EX), EX/MEM loads bubble, cnt decrements.
  - At cnt==1, the next edge returns to IDLE and EX/MEM captures the mult.
  - A mult back-to-back with a mult re-enters BUSY.
- EX/MEM: mem_* ← ex_reg_write, ex_mem_to_reg, ex_dest each edge unless BUSY.

## Timing
- All ex_*, mem_*, FSM state and cnt register on the rising edge of clk. pc_write, ifid_write, if_flush and pc_src are combinational from ID inputs plus registered state, valid the same cycle.
- Reset (rst_n=0, asynchronous): all ex_*, mem_* and cnt = 0, FSM IDLE, mul_busy=0. With id_valid=0: pc_write=ifid_write=1, if_flush=0, pc_src=00.
- Reset mid-multiply aborts immediately. No state survives reset.
- Load-use: exactly 1 stall cycle.
- Branch after ALU producer: 1 stall cycle, plus 1 more if the producer is lw.
- mult: front end frozen MUL_LAT-1 cycles after issue.
- Deassertion of rst_n is synchronised externally.

## Test plan
- Reset: rst_n=0 mid-mult with cnt=2 → mul_busy=0 and ex_*=0 immediately. After release with id_valid=0 → pc_write=1, pc_src=00.
- Load-use: lw r8 then add r9,r8,r1 → one cycle of pc_write=0, ifid_write=0 and ID/EX bubble (ex_reg_write=0), then add issues with ex_dest=9.
- Branch: addi r4 then beq r4,r5 with equal=1 → 1 stall, then pc_src=01, if_flush=1. Same sequence with lw r4 → 2 stalls, then redirect.
- Jumps: jal → pc_src=10, if_flush=1, next cycle ex_reg_dst=10, ex_dest=31, ex_link=1. bne with equal=1 → pc_src=00.
- Multiply: mult with MUL_LAT=4 → mul_busy=1 for 3 cycles, pc_write=0 throughout, mem_reg_write=0 in those cycles, then mem_dest=rd. Back-to-back mult → 6 frozen cycles.
- Register 0: lw r0 then add r1,r0,r0 → no stall. Unknown opcode 111111 → ex_* all 0.
